// File: rtl/rvvi_trace_serializer.sv
// Retire-event trace serializer: latches one retired instruction per handshake and
// streams it out as ordered PC/INSN/MODE/TRAP/X/F key-index-value records.
//
// state  | meaning
// IDLE   | waiting for a retire event (in_ready=1)
// S_PC   | emitting PC record
// S_INSN | emitting instruction bits record
// S_MODE | emitting privilege mode record
// S_TRAP | emitting trap flag record
// S_X    | walking remaining X writeback mask, lowest index first
// S_F    | walking remaining F writeback mask, lowest index first
module rvvi_trace_serializer #(
  parameter int XLEN = 64,
  parameter int FLEN = 64,
  parameter int F_EN = 1,
  localparam int DW = (XLEN > FLEN) ? XLEN : FLEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [31:0]        in_insn,
  input  logic [1:0]         in_mode,
  input  logic               in_trap,
  input  logic [31:0]        in_x_wb,
  input  logic [32*XLEN-1:0] in_x_wdata,
  input  logic [31:0]        in_f_wb,
  input  logic [32*FLEN-1:0] in_f_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_key,
  output logic [4:0]         out_idx,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic [31:0]        inst_count
);

  typedef enum logic [2:0] {IDLE, S_PC, S_INSN, S_MODE, S_TRAP, S_X, S_F} state_t;

  localparam logic [2:0] KEY_PC   = 3'd1;
  localparam logic [2:0] KEY_INSN = 3'd2;
  localparam logic [2:0] KEY_MODE = 3'd3;
  localparam logic [2:0] KEY_TRAP = 3'd4;
  localparam logic [2:0] KEY_X    = 3'd5;
  localparam logic [2:0] KEY_F    = 3'd6;

  state_t              state, state_n;
  logic [XLEN-1:0]     pc_q;
  logic [31:0]         insn_q;
  logic [1:0]          mode_q;
  logic                trap_q;
  logic [31:0]         x_mask_q, f_mask_q;
  logic [32*XLEN-1:0]  x_data_q;
  logic [32*FLEN-1:0]  f_data_q;
  logic [31:0]         inst_count_q;
  logic [4:0]          x_idx, f_idx;
  logic [31:0]         x_rest, f_rest;
  logic                accept, fire;

  // Lowest set bit of each remaining mask; the loop runs high-to-low so the last hit wins.
  always_comb begin
    x_idx = '0;
    f_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (x_mask_q[i]) x_idx = 5'(i);
      if (f_mask_q[i]) f_idx = 5'(i);
    end
  end

  assign x_rest = x_mask_q & (x_mask_q - 32'd1);
  assign f_rest = f_mask_q & (f_mask_q - 32'd1);

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_key   = '0;
    out_idx   = '0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_PC;
      end
      S_PC: begin
        out_valid = 1'b1;
        out_key   = KEY_PC;
        out_data  = DW'(pc_q);
        if (out_ready) state_n = S_INSN;
      end
      S_INSN: begin
        out_valid = 1'b1;
        out_key   = KEY_INSN;
        out_data  = DW'(insn_q);
        if (out_ready) state_n = S_MODE;
      end
      S_MODE: begin
        out_valid = 1'b1;
        out_key   = KEY_MODE;
        out_data  = DW'(mode_q);
        if (out_ready) state_n = S_TRAP;
      end
      S_TRAP: begin
        out_valid = 1'b1;
        out_key   = KEY_TRAP;
        out_data  = DW'(trap_q);
        out_last  = (x_mask_q == '0) && (f_mask_q == '0);
        if (out_ready) begin
          if (x_mask_q != '0)      state_n = S_X;
          else if (f_mask_q != '0) state_n = S_F;
          else                     state_n = IDLE;
        end
      end
      S_X: begin
        out_valid = 1'b1;
        out_key   = KEY_X;
        out_idx   = x_idx;
        out_data  = DW'(x_data_q[x_idx*XLEN +: XLEN]);
        out_last  = (x_rest == '0) && (f_mask_q == '0);
        if (out_ready && x_rest == '0) state_n = (f_mask_q != '0) ? S_F : IDLE;
      end
      S_F: begin
        out_valid = 1'b1;
        out_key   = KEY_F;
        out_idx   = f_idx;
        out_data  = DW'(f_data_q[f_idx*FLEN +: FLEN]);
        out_last  = (f_rest == '0);
        if (out_ready && f_rest == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign fire       = out_valid && out_ready;
  assign inst_count = inst_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc_q         <= '0;
      insn_q       <= '0;
      mode_q       <= '0;
      trap_q       <= 1'b0;
      x_mask_q     <= '0;
      f_mask_q     <= '0;
      x_data_q     <= '0;
      f_data_q     <= '0;
      inst_count_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        pc_q     <= in_pc;
        insn_q   <= in_insn;
        mode_q   <= in_mode;
        trap_q   <= in_trap;
        // x0 is hardwired, so its writeback is never traced
        x_mask_q <= in_x_wb & ~32'd1;
        f_mask_q <= (F_EN != 0) ? in_f_wb : 32'd0;
        x_data_q <= in_x_wdata;
        f_data_q <= in_f_wdata;
      end
      if (fire && state == S_X) x_mask_q <= x_rest;
      if (fire && state == S_F) f_mask_q <= f_rest;
      if (fire && out_last) inst_count_q <= inst_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_rvvi_trace_serializer.sv
// Bench for rvvi_trace_serializer: expected record lists are built from the retire event
// itself and compared against the records observed on the output handshake.
module tb_rvvi_trace_serializer;
  localparam int XLEN = 64;
  localparam int FLEN = 64;
  localparam int DW   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               in_valid, out_ready;
  bit                 sel;
  logic [XLEN-1:0]    in_pc;
  logic [31:0]        in_insn;
  logic [1:0]         in_mode;
  logic               in_trap;
  logic [31:0]        in_x_wb, in_f_wb;
  logic [32*XLEN-1:0] in_x_wdata;
  logic [32*FLEN-1:0] in_f_wdata;

  logic in_valid_a, in_valid_b, out_ready_a, out_ready_b;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
  logic [2:0] out_key_a, out_key_b;
  logic [4:0] out_idx_a, out_idx_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [31:0] inst_count_a, inst_count_b;

  assign in_valid_a  = in_valid && !sel;
  assign in_valid_b  = in_valid && sel;
  assign out_ready_a = sel ? 1'b1 : out_ready;
  assign out_ready_b = sel ? out_ready : 1'b1;

  logic cur_in_ready, cur_out_valid, cur_out_last;
  logic [2:0] cur_out_key;
  logic [4:0] cur_out_idx;
  logic [DW-1:0] cur_out_data;
  logic [31:0] cur_inst_count;
  assign cur_in_ready   = sel ? in_ready_b   : in_ready_a;
  assign cur_out_valid  = sel ? out_valid_b  : out_valid_a;
  assign cur_out_last   = sel ? out_last_b   : out_last_a;
  assign cur_out_key    = sel ? out_key_b    : out_key_a;
  assign cur_out_idx    = sel ? out_idx_b    : out_idx_a;
  assign cur_out_data   = sel ? out_data_b   : out_data_a;
  assign cur_inst_count = sel ? inst_count_b : inst_count_a;

  rvvi_trace_serializer #(.XLEN(XLEN), .FLEN(FLEN), .F_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pc(in_pc), .in_insn(in_insn), .in_mode(in_mode), .in_trap(in_trap),
    .in_x_wb(in_x_wb), .in_x_wdata(in_x_wdata), .in_f_wb(in_f_wb), .in_f_wdata(in_f_wdata),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_key(out_key_a), .out_idx(out_idx_a),
    .out_data(out_data_a), .out_last(out_last_a), .inst_count(inst_count_a));

  rvvi_trace_serializer #(.XLEN(XLEN), .FLEN(FLEN), .F_EN(0)) dut_nf (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pc(in_pc), .in_insn(in_insn), .in_mode(in_mode), .in_trap(in_trap),
    .in_x_wb(in_x_wb), .in_x_wdata(in_x_wdata), .in_f_wb(in_f_wb), .in_f_wdata(in_f_wdata),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_key(out_key_b), .out_idx(out_idx_b),
    .out_data(out_data_b), .out_last(out_last_b), .inst_count(inst_count_b));

  typedef struct packed {
    logic [2:0]  key;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int stab_err;
  int exp_cnt_a, exp_cnt_b;

  // Trace-line order: PC, INSN, MODE, TRAP, then X regs 1..31, then F regs 0..31; last flag on the final one.
  task automatic model(input bit fen);
    rec_t r;
    exp_q.delete();
    exp_q.push_back('{3'd1, 5'd0, in_pc, 1'b0});
    exp_q.push_back('{3'd2, 5'd0, 64'(in_insn), 1'b0});
    exp_q.push_back('{3'd3, 5'd0, 64'(in_mode), 1'b0});
    exp_q.push_back('{3'd4, 5'd0, 64'(in_trap), 1'b0});
    for (int i = 1; i < 32; i++)
      if (in_x_wb[i]) exp_q.push_back('{3'd5, 5'(i), in_x_wdata[i*XLEN +: XLEN], 1'b0});
    if (fen)
      for (int i = 0; i < 32; i++)
        if (in_f_wb[i]) exp_q.push_back('{3'd6, 5'(i), in_f_wdata[i*FLEN +: FLEN], 1'b0});
    r = exp_q.pop_back();
    r.last = 1'b1;
    exp_q.push_back(r);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 32; i++) begin
      in_x_wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
      in_f_wdata[i*FLEN +: FLEN] = {$urandom, $urandom};
    end
  endtask

  task automatic run_event(input int stall_pct, input int stall_idx, input int stall_len,
                           output bit timeout, output bit first_valid, output logic [2:0] first_key,
                           output int cycles, output bit post_valid, output bit post_ready);
    int n;
    bit done, hold, stalled_once, rdy;
    rec_t held;
    int stall_left;
    obs_q.delete();
    stab_err = 0; timeout = 0; cycles = 0; done = 0; hold = 0;
    stall_left = 0; stalled_once = 0; held = '0;
    first_valid = 0; first_key = '0; post_valid = 0; post_ready = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    n = 0;
    while (!cur_in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin in_valid = 1'b0; timeout = 1; return; end
    @(negedge clk);
    in_valid = 1'b0;
    first_valid = cur_out_valid;
    first_key = cur_out_key;
    while (!done && cycles < 400) begin
      rdy = ($urandom_range(99) >= stall_pct);
      if (stall_idx >= 0 && cur_out_valid && cur_out_key == 3'd5 && cur_out_idx == 5'(stall_idx) && !stalled_once) begin
        stall_left = stall_len;
        stalled_once = 1;
      end
      if (stall_left > 0) begin rdy = 0; stall_left--; end
      out_ready = rdy;
      if (hold && (!cur_out_valid || cur_out_key !== held.key || cur_out_idx !== held.idx ||
                   cur_out_data !== held.data || cur_out_last !== held.last)) stab_err++;
      hold = 0;
      if (cur_out_valid) begin
        if (rdy) begin
          obs_q.push_back('{cur_out_key, cur_out_idx, cur_out_data, cur_out_last});
          if (cur_out_last) done = 1;
        end else begin
          hold = 1;
          held = '{cur_out_key, cur_out_idx, cur_out_data, cur_out_last};
        end
      end
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b1;
    if (!done) timeout = 1;
    post_valid = cur_out_valid;
    post_ready = cur_in_ready;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (cur_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", cur_in_ready); else pass_cnt++;
    total_cnt++; if (cur_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", cur_out_valid); else pass_cnt++;
    total_cnt++; if ({cur_out_key, cur_out_idx, cur_out_data, cur_out_last} !== '0)
      $display("FAIL reset_outputs got key=%0d idx=%0d data=%h last=%b want all 0", cur_out_key, cur_out_idx, cur_out_data, cur_out_last);
    else pass_cnt++;
    total_cnt++; if (cur_inst_count !== 32'd0) $display("FAIL reset_inst_count got %0d want 0", cur_inst_count); else pass_cnt++;
  endtask

  task automatic test_basic();
    bit to, fv, pv, pr; logic [2:0] fk; int cyc;
    sel = 0; rand_data();
    in_pc = 64'h8000_0000; in_insn = 32'h0050_0093; in_mode = 2'd3; in_trap = 1'b0;
    in_x_wb = 32'h2; in_f_wb = 32'h0; in_x_wdata[1*XLEN +: XLEN] = 64'd5;
    model(1);
    run_event(0, -1, 0, to, fv, fk, cyc, pv, pr);
    exp_cnt_a++;
    total_cnt++; if (to !== 1'b0) $display("FAIL basic_timeout got %b want 0", to); else pass_cnt++;
    total_cnt++; if (fv !== 1'b1 || fk !== 3'd1) $display("FAIL basic_latency got valid=%b key=%0d want valid=1 key=1", fv, fk); else pass_cnt++;
    total_cnt++; if (cyc !== 5) $display("FAIL basic_cycles got %0d want 5", cyc); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL basic_len got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL basic_rec[%0d] got key=%0d idx=%0d data=%h last=%b want key=%0d idx=%0d data=%h last=%b",
        i, obs_q[i].key, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].key, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      else pass_cnt++;
    end
    total_cnt++; if (cur_inst_count !== 32'(exp_cnt_a)) $display("FAIL basic_inst_count got %0d want %0d", cur_inst_count, exp_cnt_a); else pass_cnt++;
    total_cnt++; if (pv !== 1'b0 || pr !== 1'b1) $display("FAIL basic_return_idle got valid=%b ready=%b want 0 1", pv, pr); else pass_cnt++;
  endtask

  task automatic test_xf_masks();
    bit to, fv, pv, pr; logic [2:0] fk; int cyc;
    sel = 0; rand_data();
    in_pc = {$urandom, $urandom}; in_insn = $urandom; in_mode = 2'd0; in_trap = 1'b0;
    in_x_wb = 32'h8000_0005; in_f_wb = 32'h0000_0009;
    model(1);
    run_event(0, -1, 0, to, fv, fk, cyc, pv, pr);
    exp_cnt_a++;
    total_cnt++; if (to !== 1'b0) $display("FAIL xf_timeout got %b want 0", to); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL xf_len got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL xf_rec[%0d] got key=%0d idx=%0d data=%h last=%b want key=%0d idx=%0d data=%h last=%b",
        i, obs_q[i].key, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].key, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      else pass_cnt++;
    end
    total_cnt++; if (cur_inst_count !== 32'(exp_cnt_a)) $display("FAIL xf_inst_count got %0d want %0d", cur_inst_count, exp_cnt_a); else pass_cnt++;
  endtask

  task automatic test_trap_only();
    bit to, fv, pv, pr; logic [2:0] fk; int cyc;
    sel = 0; rand_data();
    in_pc = {$urandom, $urandom}; in_insn = $urandom; in_mode = 2'd1; in_trap = 1'b1;
    in_x_wb = 32'h0; in_f_wb = 32'h0;
    model(1);
    run_event(0, -1, 0, to, fv, fk, cyc, pv, pr);
    exp_cnt_a++;
    total_cnt++; if (obs_q.size() !== 4) $display("FAIL trap_len got %0d want 4", obs_q.size()); else pass_cnt++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL trap_rec[%0d] got key=%0d idx=%0d data=%h last=%b want key=%0d idx=%0d data=%h last=%b",
        i, obs_q[i].key, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].key, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      else pass_cnt++;
    end
    total_cnt++; if (cur_inst_count !== 32'(exp_cnt_a)) $display("FAIL trap_inst_count got %0d want %0d", cur_inst_count, exp_cnt_a); else pass_cnt++;
  endtask

  task automatic test_stall();
    bit to, fv, pv, pr; logic [2:0] fk; int cyc;
    sel = 0; rand_data();
    in_pc = {$urandom, $urandom}; in_insn = $urandom; in_mode = 2'd2; in_trap = 1'b0;
    in_x_wb = 32'h0000_0488; in_f_wb = 32'h0000_0002;
    model(1);
    run_event(0, 7, 5, to, fv, fk, cyc, pv, pr);
    exp_cnt_a++;
    total_cnt++; if (stab_err !== 0) $display("FAIL stall_stable got %0d changes want 0", stab_err); else pass_cnt++;
    total_cnt++; if (cyc !== exp_q.size() + 5) $display("FAIL stall_cycles got %0d want %0d", cyc, exp_q.size() + 5); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL stall_len got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL stall_rec[%0d] got key=%0d idx=%0d data=%h last=%b want key=%0d idx=%0d data=%h last=%b",
        i, obs_q[i].key, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].key, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    bit to, fv, pv, pr; logic [2:0] fk; int cyc;
    sel = 0;
    for (int n = 0; n < 8; n++) begin
      rand_data();
      in_pc = {$urandom, $urandom}; in_insn = $urandom; in_mode = 2'($urandom); in_trap = 1'($urandom);
      in_x_wb = $urandom & $urandom; in_f_wb = $urandom & $urandom & $urandom;
      model(1);
      run_event(30, -1, 0, to, fv, fk, cyc, pv, pr);
      exp_cnt_a++;
      total_cnt++; if (stab_err !== 0) $display("FAIL rand%0d_stable got %0d changes want 0", n, stab_err); else pass_cnt++;
      total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL rand%0d_len got %0d want %0d", n, obs_q.size(), exp_q.size()); else pass_cnt++;
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        total_cnt++;
        if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_rec[%0d] got key=%0d idx=%0d data=%h last=%b want key=%0d idx=%0d data=%h last=%b",
          n, i, obs_q[i].key, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].key, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
        else pass_cnt++;
      end
      total_cnt++; if (cur_inst_count !== 32'(exp_cnt_a)) $display("FAIL rand%0d_inst_count got %0d want %0d", n, cur_inst_count, exp_cnt_a); else pass_cnt++;
    end
  endtask

  task automatic test_no_fen();
    bit to, fv, pv, pr; logic [2:0] fk; int cyc;
    sel = 1; rand_data();
    in_pc = {$urandom, $urandom}; in_insn = $urandom; in_mode = 2'd3; in_trap = 1'($urandom);
    in_x_wb = 32'h0; in_f_wb = 32'hFFFF_FFFF;
    model(0);
    run_event(20, -1, 0, to, fv, fk, cyc, pv, pr);
    exp_cnt_b++;
    total_cnt++; if (obs_q.size() !== 4) $display("FAIL nofen_len got %0d want 4", obs_q.size()); else pass_cnt++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL nofen_rec[%0d] got key=%0d idx=%0d data=%h last=%b want key=%0d idx=%0d data=%h last=%b",
        i, obs_q[i].key, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].key, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      else pass_cnt++;
    end
    total_cnt++; if (cur_inst_count !== 32'(exp_cnt_b)) $display("FAIL nofen_inst_count got %0d want %0d", cur_inst_count, exp_cnt_b); else pass_cnt++;
    sel = 0;
  endtask

  task automatic test_reset_mid();
    bit to, fv, pv, pr; logic [2:0] fk; int cyc, n;
    do_reset();
    sel = 0; rand_data();
    in_pc = {$urandom, $urandom}; in_insn = $urandom; in_mode = 2'd3; in_trap = 1'b0;
    in_x_wb = 32'h0000_00F0; in_f_wb = 32'h0000_0010;
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (cur_out_key !== 3'd2 && n < 20) begin @(negedge clk); n++; end
    total_cnt++; if (cur_out_key !== 3'd2) $display("FAIL rstmid_reach_insn got key=%0d want 2", cur_out_key); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++; if (cur_out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", cur_out_valid); else pass_cnt++;
    total_cnt++; if (cur_in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", cur_in_ready); else pass_cnt++;
    total_cnt++; if (cur_inst_count !== 32'(exp_cnt_a)) $display("FAIL rstmid_inst_count got %0d want %0d", cur_inst_count, exp_cnt_a); else pass_cnt++;
    model(1);
    run_event(25, -1, 0, to, fv, fk, cyc, pv, pr);
    exp_cnt_a++;
    total_cnt++; if (fv !== 1'b1 || fk !== 3'd1) $display("FAIL rstmid_restart got valid=%b key=%0d want valid=1 key=1", fv, fk); else pass_cnt++;
    total_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL rstmid_len got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      total_cnt++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rstmid_rec[%0d] got key=%0d idx=%0d data=%h last=%b want key=%0d idx=%0d data=%h last=%b",
        i, obs_q[i].key, obs_q[i].idx, obs_q[i].data, obs_q[i].last, exp_q[i].key, exp_q[i].idx, exp_q[i].data, exp_q[i].last);
      else pass_cnt++;
    end
    total_cnt++; if (cur_inst_count !== 32'(exp_cnt_a)) $display("FAIL rstmid_final_count got %0d want %0d", cur_inst_count, exp_cnt_a); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 0;
    in_pc = '0; in_insn = '0; in_mode = '0; in_trap = 1'b0;
    in_x_wb = '0; in_f_wb = '0; in_x_wdata = '0; in_f_wdata = '0;
    exp_cnt_a = 0; exp_cnt_b = 0;
    test_reset();
    test_basic();
    test_xf_masks();
    test_trap_only();
    test_stall();
    test_random();
    test_no_fen();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rvvi_trace_serializer.md
Name: rvvi_trace_serializer

Overview:
- Writer side of the coverage trace flow: captures one retired-instruction event per handshake and serializes it into an ordered stream of key/index/value records.
- Each record maps 1:1 onto a trace-line token (PC, INSN, MODE, TRAP, X, F).
- Sits between a core's retire stage and a trace sink (DPI file writer or FPGA FIFO). Downstream the stream is formatted into the text lines the coverage testbench consumes.

Parameters:
- XLEN, 64, integer register width (32 or 64).
- FLEN, 64, FP register width (32 or 64).
- F_EN, 1, 1 = emit F records; 0 = ignore f_wb entirely.
- DW, max(XLEN,FLEN), record data width; derived, not overridden.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  retire event present
- in_ready  output  1  serializer can accept event
- in_pc  input  XLEN  retired PC
- in_insn  input  32  instruction bits
- in_mode  input  2  privilege mode
- in_trap  input  1  instruction trapped
- in_x_wb  input  32  X writeback mask
- in_x_wdata  input  32*XLEN  packed X write data, reg i at [i*XLEN +: XLEN]
- in_f_wb  input  32  F writeback mask
- in_f_wdata  input  32*FLEN  packed F write data
- out_valid  output  1  record valid
- out_ready  input  1  sink accepts record
- out_key  output  3  1=PC 2=INSN 3=MODE 4=TRAP 5=X 6=F
- out_idx  output  5  register index (0 for non-register keys)
- out_data  output  DW  value, zero-extended
- out_last  output  1  final record of this instruction
- inst_count  output  32  instructions fully emitted

Behaviour:
- Reset (synchronous): state IDLE; in_ready=1; out_valid=0; out_key=0; out_idx=0; out_data=0; out_last=0; inst_count=0; capture register cleared.
- Reset mid-instruction discards all remaining records; no partial completion is counted.
- in_ready = (state==IDLE). An event is accepted on a cycle with in_valid && in_ready. All inputs are latched into the capture register on that edge.
- Capture: x mask is stored with bit0 forced to 0. f mask is stored as zero when F_EN=0.
- FSM states: IDLE -> S_PC -> S_INSN -> S_MODE -> S_TRAP -> S_X -> S_F -> IDLE.
- S_X and S_F are skipped when their remaining mask is zero.
- First record (PC) has out_valid=1 the cycle after acceptance (latency 1).
- A record advances only on out_valid && out_ready. While out_ready=0, all out_* are held stable.
- X/F walk: emit the lowest set bit of the remaining mask, then clear that bit on handshake. Indices are strictly ascending, one record per set bit.
- out_last=1 on exactly one record per instruction: the last F record if any, else the last X record if any, else the TRAP record.
- Record data:
  - PC: zero-extended from XLEN.
  - INSN: zero-extended 32 bits.
  - MODE: zero-extended 2 bits.
  - TRAP: 0/1.
  - X: XLEN, zero-extended.
  - F: FLEN, zero-extended; FLEN=32 values are not NaN-boxed.
- On the handshake of the out_last record: inst_count increments (wraps at 2^32); state returns to IDLE; out_valid deasserts the next cycle.
- Throughput: 4 + popcount(x) + popcount(f) records per instruction, plus one IDLE cycle between instructions.
- in_valid while in_ready=0 is ignored. The source must hold the event until it is accepted.

Test Plan:
- Reset, then event pc=0x80000000, insn=0x00500093, mode=3, trap=0, x_wb=0x2, x_wdata[1]=5, out_ready=1 -> PC, INSN, MODE, TRAP, X(1,5 with last) on consecutive cycles starting 1 cycle after accept; inst_count=1.
- Event with x_wb=0x80000005 (x0,x2,x31), f_wb=0x00000009 (f0,f3) -> X idx 2,31 then F idx 0,3; last only on F3; x0 never emitted.
- Event with trap=1, both masks 0 -> 4 records, TRAP record has data=1 and out_last=1.
- Hold out_ready=0 for 5 cycles during the X record of reg 7 -> key/idx/data/last stable throughout; the record completes one cycle after out_ready rises.
- F_EN=0, f_wb=0xFFFFFFFF, x_wb=0 -> no F records; TRAP record is last.
- Assert reset during the INSN record -> next cycle out_valid=0, in_ready=1, inst_count unchanged. A subsequent event serializes fully from PC.
